index_mask_decoder: RTL
=======================

// Module: index_mask_decoder
// PURPOSE
//  Receive end of the priority-encoder link.
//  Accepts a stream of encoded beats {idx, nz} framed by a last flag, and rebuilds the request bitmask they encode.
//  Decoded per-beat one-hot values are OR-accumulated into a frame mask.
//  The frame mask is presented with a ready/valid handshake to the downstream arbiter/checker.
// PARAMETERS
//  N_OUT  4  width of rebuilt mask; index width IW = $clog2(N_OUT) (localparam, min 1)
// PORTS
//  clk         in   1       rising-edge clock; single clock domain
//  reset_n     in   1       synchronous, active-low reset
//  in_stb      in   1       input beat offered
//  in_ready    out  1       block can accept a beat; transfer when in_stb & in_ready
//  in_idx      in   IW      encoded index (encoder y)
//  in_nz       in   1       encoder valid flag; 0 = no request bits in this beat
//  in_last     in   1       final beat of frame
//  out_vld     out  1       frame mask available
//  out_rdy     in   1       downstream accepts; transfer when out_vld & out_rdy
//  out_mask    out  N_OUT   rebuilt request mask
//  out_err     out  1       frame had duplicate or out-of-range index
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge):
//   - state=IDLE; accumulator=0; out_mask=0; out_vld=0; out_err=0.
//   - in_ready=0 while reset_n=0.
//  FSM states:
//   - IDLE: accumulator empty; in_ready=1. Accepted beat -> ACCUM, or -> HOLD if in_last.
//   - ACCUM: in_ready=1. Accepted beat updates the accumulator. Accepted beat with in_last -> HOLD.
//   - HOLD: in_ready=0; out_vld=1.
//     out_mask/out_err stable until the cycle with out_rdy=1.
//     That handshake -> IDLE; accumulator and err are cleared in the same edge.
//  Beat decode:
//   - nz=1 and idx<N_OUT: accumulator |= (1<<idx).
//   - Bit already set: accumulator unchanged; err flag set.
//   - nz=1 and idx>=N_OUT (non-pow2 N_OUT only): bit dropped; err set.
//   - nz=0: no mask change, no error; in_idx is don't-care.
//  Latency: out_vld rises the cycle after the clk edge that accepts the in_last beat.
//   - out_mask at that point includes the last beat.
//  Simultaneous out handshake and in_stb in HOLD:
//   - beat is not accepted (in_ready=0).
//   - It is accepted in IDLE on the following cycle (one bubble per frame, by design).
//  in_stb=0 in ACCUM: accumulator holds indefinitely; no timeout.
//  Reset mid-frame or in HOLD: partial/held frame discarded; no stale bits reach the next frame.
//  Inputs are sampled only on accepted beats. in_* may change freely when in_ready=0.
// CONFIGURATION
//  IDX_DEC_ONEHOT_EN defined:
//   - Adds output ports beat_vld (1) and beat_onehot (N_OUT).
//   - Each accepted beat produces a registered 1-cycle beat_vld pulse on the next cycle.
//   - beat_onehot = 1<<idx, or 0 if nz=0 or idx out of range.
//   - Reset value 0 for both.
//  Not defined: ports and logic absent; frame behaviour identical.
// TESTING (N_OUT=4)
//  1. Frame {idx0,nz1},{idx2,nz1,last}: out_vld the next cycle, out_mask=4'b0101, out_err=0.
//  2. Single beat {nz0,last}: out_vld=1, out_mask=4'b0000, out_err=0.
//  3. Frame idx3, idx3(last): out_mask=4'b1000, out_err=1.
//     Next frame idx1(last): out_mask=4'b0010, out_err=0.
//  4. Backpressure: hold out_rdy=0 for 5 cycles in HOLD.
//     out_vld/out_mask stable and in_ready=0 throughout.
//     Raise out_rdy: next cycle out_vld=0, in_ready=1.
//  5. Reset mid-frame: accept idx1, pulse reset_n=0 one cycle, send idx2(last).
//     out_mask=4'b0100, out_err=0.
//  6. All 16 encoder input values a=0..15, each sent as a one-beat frame with the encoder's {y,valid}:
//     out_mask=0 for a=0, else one-hot of the MSB set in a.
//     With IDX_DEC_ONEHOT_EN: beat_onehot equals out_mask.

Source files
------------

// File: rtl/index_mask_decoder_if.sv
//------------------------------------------------------------------------------
// Module  : index_mask_decoder_if
// Purpose : Beat input and frame-mask output handshakes of index_mask_decoder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface index_mask_decoder_if #(
  parameter int N_OUT = 4
);
  localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic             in_stb;
  logic             in_ready;
  logic [IW-1:0]    in_idx;
  logic             in_nz;
  logic             in_last;
  logic             out_vld;
  logic             out_rdy;
  logic [N_OUT-1:0] out_mask;
  logic             out_err;

  // master drives beats and consumes masks; slave is the decoder
  modport master (
    output in_stb, in_idx, in_nz, in_last, out_rdy,
    input  in_ready, out_vld, out_mask, out_err
  );

  modport slave (
    input  in_stb, in_idx, in_nz, in_last, out_rdy,
    output in_ready, out_vld, out_mask, out_err
  );
endinterface

`default_nettype wire

// File: rtl/index_mask_decoder.sv
//------------------------------------------------------------------------------
// Module  : index_mask_decoder
// Purpose : Rebuilds a request bitmask from a framed stream of {idx, nz} beats.
//           Optional per-beat one-hot tap enabled by IDX_DEC_ONEHOT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module index_mask_decoder #(
  parameter int N_OUT = 4
) (
  input  wire logic            clk,
  input  wire logic            reset_n,
  index_mask_decoder_if.slave  bus
`ifdef IDX_DEC_ONEHOT_EN
  ,
  output logic                 beat_vld,
  output logic [N_OUT-1:0]     beat_onehot
`endif
);

  localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IW:0] C_N_OUT = (IW+1)'(N_OUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [N_OUT-1:0] r_acc;
  logic             r_err;
  logic             r_vld;

  logic             w_accept;
  logic             w_in_range;
  logic             w_dup;
  logic             w_beat_err;
  logic [N_OUT-1:0] w_onehot;

  assign bus.in_ready = reset_n && (r_state != S_HOLD);
  assign w_accept     = bus.in_stb && bus.in_ready;

  // Out-of-range indices only exist when N_OUT is not a power of two
  always_comb begin
    w_in_range = ({1'b0, bus.in_idx} < C_N_OUT);
    w_onehot   = '0;
    for (int i = 0; i < N_OUT; i++) begin
      w_onehot[i] = bus.in_nz && w_in_range && (bus.in_idx == IW'(i));
    end
    w_dup      = |(w_onehot & r_acc);
    w_beat_err = bus.in_nz && (!w_in_range || w_dup);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_err   <= 1'b0;
      r_vld   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_accept) begin
            r_acc <= r_acc | w_onehot;
            r_err <= r_err | w_beat_err;
            if (bus.in_last) begin
              r_state <= S_HOLD;
              r_vld   <= 1'b1;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_HOLD: begin
          // Clearing here leaves IDLE with an empty accumulator
          if (bus.out_rdy) begin
            r_state <= S_IDLE;
            r_vld   <= 1'b0;
            r_acc   <= '0;
            r_err   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_vld   <= 1'b0;
          r_acc   <= '0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_vld  = r_vld;
  assign bus.out_mask = r_acc;
  assign bus.out_err  = r_err;

`ifdef IDX_DEC_ONEHOT_EN
  logic             r_beat_vld;
  logic [N_OUT-1:0] r_beat_onehot;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_beat_vld    <= 1'b0;
      r_beat_onehot <= '0;
    end else begin
      r_beat_vld    <= w_accept;
      r_beat_onehot <= w_accept ? w_onehot : '0;
    end
  end

  assign beat_vld    = r_beat_vld;
  assign beat_onehot = r_beat_onehot;
`endif

endmodule

`default_nettype wire
